// File: rtl/alu_job_driver_if.sv
// Handshake and bus bundle between the job source, the ALU and the result consumer.
interface alu_job_driver_if;
    // Command port
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    // ALU side
    logic        alu_en;
    logic [1:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_y;
    logic        alu_valid;
    // Result port
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [1:0]  res_op;

    // Driver view: takes commands, drives the ALU, offers results.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_valid, res_ready,
        output cmd_ready, alu_en, alu_op, alu_a, alu_b, res_valid, res_data, res_op
    );

    // Environment view: job source, ALU and result consumer.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_valid, res_ready,
        input  cmd_ready, alu_en, alu_op, alu_a, alu_b, res_valid, res_data, res_op
    );
endinterface

// File: rtl/alu_job_driver.sv
// Initiator-side ALU front end: issues one job at a time, captures the result into a
// show-ahead FIFO, throttles issue with a programmable gap and flags ALU protocol faults.
module alu_job_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_job_driver_if.slave  bus,
    input  logic [3:0]       gap,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_stray,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

    state_e          state_q;
    logic [TW-1:0]   tmo_q;
    logic [3:0]      gap_q;
    logic [65:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    assign push = (state_q == StWait) && bus.alu_valid;
    assign pop  = bus.res_valid && bus.res_ready;

    // Space is checked at accept time, so the single outstanding job always has a slot.
    assign bus.cmd_ready = (state_q == StIdle) && (count_q < CW'(DEPTH));
    assign busy          = (state_q != StIdle);

    // Head is masked to zero when empty so the outputs read 0 out of reset.
    assign bus.res_valid = (count_q != '0);
    assign bus.res_data  = bus.res_valid ? mem_q[rd_ptr_q][63:0]  : '0;
    assign bus.res_op    = bus.res_valid ? mem_q[rd_ptr_q][65:64] : '0;

    // Job sequencing FSM with registered ALU drive, counters and sticky fault flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            gap_q       <= '0;
            bus.alu_en  <= 1'b0;
            bus.alu_op  <= '0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            err_timeout <= 1'b0;
            err_stray   <= 1'b0;
            issued_cnt  <= '0;
            done_cnt    <= '0;
        end else begin
            bus.alu_en <= 1'b0;
            if (bus.alu_valid && (state_q != StWait)) begin
                err_stray <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.alu_op <= bus.cmd_op;
                        bus.alu_a  <= bus.cmd_a;
                        bus.alu_b  <= bus.cmd_b;
                        bus.alu_en <= 1'b1;
                        issued_cnt <= issued_cnt + 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    tmo_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (bus.alu_valid) begin
                        done_cnt <= done_cnt + 1'b1;
                        tmo_q    <= '0;
                        gap_q    <= gap;
                        state_q  <= (gap == 4'd0) ? StIdle : StGap;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_q <= 4'd1) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave the count alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // FIFO storage: {op, y} per entry, no reset needed since occupancy gates the head.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {bus.alu_op, bus.alu_y};
        end
    end

endmodule
